// File: rtl/latch_dump_sequencer.sv
// Debug-unit frame dumper: walks the latch-mux selector table, captures each
// 32-bit word into a shadow register and streams it LSB-first to the UART.
module latch_dump_sequencer #(
  parameter int unsigned MUX_LAT  = 1,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter bit          SEND_HDR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dump_req,
  output logic [6:0]  mux_sel,
  input  logic [31:0] mux_data,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        busy,
  output logic        done,
  output logic [4:0]  word_idx
);

  localparam int unsigned CNT_W    = (MUX_LAT > 1) ? $clog2(MUX_LAT) : 1;
  localparam logic [4:0]  LAST_IDX = 5'd18;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_HDR_WAIT,
    S_SEL,
    S_SETTLE,
    S_CAPTURE,
    S_BSEND,
    S_BWAIT,
    S_NEXT,
    S_DONE
  } state_e;

  // Only listed codes are legal; anything else makes the mux float (22 included).
  function automatic logic [6:0] code_at(input logic [4:0] idx);
    case (idx)
      5'd0:    return 7'h00;
      5'd1:    return 7'h01;
      5'd2:    return 7'h10;
      5'd3:    return 7'h11;
      5'd4:    return 7'h12;
      5'd5:    return 7'h13;
      5'd6:    return 7'h14;
      5'd7:    return 7'h15;
      5'd8:    return 7'h20;
      5'd9:    return 7'h21;
      5'd10:   return 7'h23;
      5'd11:   return 7'h24;
      5'd12:   return 7'h25;
      5'd13:   return 7'h30;
      5'd14:   return 7'h31;
      5'd15:   return 7'h32;
      5'd16:   return 7'h33;
      5'd17:   return 7'h40;
      5'd18:   return 7'h41;
      default: return 7'h00;
    endcase
  endfunction

  state_e             state_q,      state_d;
  logic [6:0]         mux_sel_q,    mux_sel_d;
  logic [7:0]         tx_data_q,    tx_data_d;
  logic               tx_start_q,   tx_start_d;
  logic               busy_q,       busy_d;
  logic               done_q,       done_d;
  logic [4:0]         word_idx_q,   word_idx_d;
  logic [1:0]         byte_cnt_q,   byte_cnt_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [31:0]        shadow_q,     shadow_d;
  logic [1:0]         next_byte;

  assign next_byte = byte_cnt_q + 2'd1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let later flops see updated ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mux_sel_q    <= 7'h00;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      word_idx_q   <= 5'd0;
      byte_cnt_q   <= 2'd0;
      settle_cnt_q <= '0;
      shadow_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      mux_sel_q    <= mux_sel_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      shadow_q     <= shadow_d;
    end
  end

  // tx_start and done are loaded on entry to HDR/BSEND/DONE, so the pulse
  // coincides with that state and a same-cycle tx_done is not in a WAIT state.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d      = state_q;
    mux_sel_d    = mux_sel_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    word_idx_d   = word_idx_q;
    byte_cnt_d   = byte_cnt_q;
    settle_cnt_d = settle_cnt_q;
    shadow_d     = shadow_q;

    case (state_q)
      S_IDLE: begin
        if (dump_req) begin
          busy_d     = 1'b1;
          word_idx_d = 5'd0;
          if (SEND_HDR) begin
            tx_start_d = 1'b1;
            tx_data_d  = HDR_BYTE;
            state_d    = S_HDR;
          end else begin
            state_d = S_SEL;
          end
        end
      end

      S_HDR: state_d = S_HDR_WAIT;

      S_HDR_WAIT: begin
        if (tx_done) state_d = S_SEL;
      end

      S_SEL: begin
        mux_sel_d    = code_at(word_idx_q);
        settle_cnt_d = '0;
        state_d      = (MUX_LAT == 0) ? S_CAPTURE : S_SETTLE;
      end

      // SETTLE plus CAPTURE give MUX_LAT+1 edges between the select change and the sample.
      S_SETTLE: begin
        if (settle_cnt_q == CNT_W'(MUX_LAT - 1)) begin
          state_d = S_CAPTURE;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      S_CAPTURE: begin
        shadow_d   = mux_data;
        byte_cnt_d = 2'd0;
        tx_data_d  = mux_data[7:0];
        tx_start_d = 1'b1;
        state_d    = S_BSEND;
      end

      S_BSEND: state_d = S_BWAIT;

      S_BWAIT: begin
        if (tx_done) begin
          if (byte_cnt_q != 2'd3) begin
            byte_cnt_d = next_byte;
            tx_data_d  = shadow_q[{next_byte, 3'b000} +: 8];
            tx_start_d = 1'b1;
            state_d    = S_BSEND;
          end else begin
            state_d = S_NEXT;
          end
        end
      end

      S_NEXT: begin
        if (word_idx_q == LAST_IDX) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          mux_sel_d  = 7'h00;
          word_idx_d = 5'd0;
          state_d    = S_DONE;
        end else begin
          word_idx_d = word_idx_q + 5'd1;
          state_d    = S_SEL;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign mux_sel  = mux_sel_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign word_idx = word_idx_q;

endmodule

// File: doc/latch_dump_sequencer.md
Name: latch_dump_sequencer

Overview:
Debug-unit controller that walks the pipeline latch-select mux through every valid selector code. It captures each registered 32-bit word and streams it as bytes to the UART transmitter over a start/done handshake. It sits between the debug command decoder, which issues dump_req after each step or at halt, and the latch mux plus UART TX. It owns the mux select lines exclusively.

Parameters:
MUX_LAT, 1, clock edges from a mux_sel change until mux_data reflects it. The latch mux registers its output, so the value is 1.
HDR_BYTE, 8'hA5, frame header byte sent before the first word.
SEND_HDR, 1, 1 = send the header byte, 0 = omit it.

Ports:
clk  in  1  system clock
rst  in  1  reset
dump_req  in  1  single-cycle request to start one frame dump
mux_sel  out  7  selector code driven to the latch mux
mux_data  in  32  registered word from the latch mux
tx_data  out  8  byte to the UART transmitter
tx_start  out  1  one-cycle pulse; tx_data is valid in the same cycle
tx_done  in  1  one-cycle pulse from the UART when the byte has been fully shifted out
busy  out  1  high from request acceptance until the frame completes
done  out  1  one-cycle pulse after the last byte's tx_done
word_idx  out  5  index of the current code-table entry (0..18)

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk. All outputs are registered.
- Reset values: mux_sel=7'h00, tx_data=8'h00, tx_start=0, busy=0, done=0, word_idx=0, state=IDLE.
- Code table: 19 fixed entries, walked in this order: 00,01 | 10,11,12,13,14,15 | 20,21,23,24,25 | 30,31,32,33 | 40,41 (hex).
  - 22 is not a valid code and is never issued.
  - No other code is ever issued, because unlisted codes make the mux drive Z.
- States:
  - IDLE: on dump_req, set busy=1 and word_idx=0. Go to HDR if SEND_HDR=1, else go to SEL.
  - HDR: pulse tx_start with tx_data=HDR_BYTE, then go to HDR_WAIT.
  - HDR_WAIT: wait for tx_done, then go to SEL.
  - SEL: load mux_sel=table[word_idx], clear the settle counter, then go to SETTLE.
  - SETTLE: hold for MUX_LAT+1 cycles after mux_sel updates, then go to CAPTURE.
  - CAPTURE: latch mux_data into the 32-bit shadow register, set byte_cnt=0, then go to BSEND.
  - BSEND: pulse tx_start with tx_data=shadow[8*byte_cnt+7 : 8*byte_cnt] (LSB first), then go to BWAIT.
  - BWAIT: on tx_done, if byte_cnt<3, increment byte_cnt and go to BSEND. Otherwise go to NEXT.
  - NEXT: if word_idx==18, go to DONE. Otherwise increment word_idx and go to SEL.
  - DONE: pulse done=1, set busy=0, return mux_sel to 7'h00 and word_idx to 0, then go to IDLE.
- Frame length: 1+76 = 77 bytes when SEND_HDR=1, 76 bytes otherwise.
- tx_start is never asserted in two consecutive cycles, and never asserted before the prior byte's tx_done.
- The shadow register is the only source of tx_data. mux_data may change after CAPTURE without effect on the bytes being sent.
- tx_done arriving in any state other than HDR_WAIT or BWAIT is ignored.
- tx_done arriving in the same cycle as tx_start (in HDR or BSEND) is ignored. Only tx_done sampled in a WAIT state counts.
- dump_req while busy=1 is ignored and does not queue.
- dump_req in the same cycle as the DONE state is also ignored.
- mux_sel changes only in SEL and DONE. It is stable for the whole time its word is being captured and transmitted.
- Reset mid-frame: all outputs return immediately to their reset values. The partial frame is abandoned; the host detects this by header resync.
- No timeout: if tx_done never arrives, the block waits indefinitely with busy=1.

Test Plan:
- Nominal dump: UART model returns tx_done 3 cycles after each tx_start. One dump_req gives 77 tx_start pulses, first byte 0xA5, and one done pulse after the 77th tx_done.
- Byte order and settle: mux model returns {1'b0,sel} replicated into all 4 bytes of the word with 1-cycle registered latency. Word 2 arrives as bytes 10,10,10,10. mux_data is sampled exactly 2 cycles after the mux_sel change.
- Code sequence: log mux_sel changes. The logged sequence must equal the 19-entry table. Code 22 never appears, and mux_sel returns to 00 after done.
- Busy collision: assert dump_req at cycle 50 of an active frame and in the DONE cycle. Exactly one frame results (77 bytes), and busy falls once.
- Spurious handshake: inject tx_done during SETTLE and in the tx_start cycle. No byte is skipped and the total count stays 77.
- Reset mid-frame: assert rst while in BWAIT of word 7. Outputs return to reset values within the same cycle. A new dump_req then yields a full 77-byte frame starting with 0xA5.
